cla_adder_pipe: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor for the FMA mantissa datapath.

---
 rtl/fma_pkg.sv | 17 +
 rtl/cla_adder_pipe_if.sv | 28 ++
 rtl/cla_group4.sv | 28 ++
 rtl/cla_adder_pipe.sv | 120 ++++++++++++
 tb/tb_cla_adder_pipe.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fma_pkg.sv
// Shared constants and helpers for the FMA mantissa datapath.
// The carry-lookahead pipeline derives its stage count and legality from here.
package fma_pkg;

  localparam int unsigned CLA_GRP_W = 4;

  function automatic int unsigned cla_stages(input int unsigned width, input int unsigned grp);
    if (grp == 0) return 0;
    return width / (CLA_GRP_W * grp);
  endfunction

  function automatic bit cla_width_ok(input int unsigned width, input int unsigned grp);
    if (grp == 0 || width == 0) return 1'b0;
    return (width % (CLA_GRP_W * grp)) == 0;
  endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand and result handshake bundle for the pipelined CLA adder/subtractor.
// master = producer/consumer side, slave = the adder itself.
interface cla_adder_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, in_a, in_b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, in_a, in_b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf, zero
  );
endinterface

// File: rtl/cla_group4.sv
// Purely combinational 4-bit carry-lookahead group: generate/propagate,
// two-level lookahead for the internal carries and the group carry out.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  logic       grp_g;
  logic       grp_p;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    c_out = grp_g | (grp_p & c_in);
    s     = p ^ c;
  end
endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves GRP_PER_STG
// 4-bit groups and registers the carry for the next slice.
module cla_adder_pipe
  import fma_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned GRP_PER_STG = 2
) (
  input logic              clk,
  input logic              rst_n,
  cla_adder_pipe_if.slave  bus
);

  localparam int unsigned SW         = CLA_GRP_W * GRP_PER_STG;
  localparam int unsigned STAGES_RAW = cla_stages(WIDTH, GRP_PER_STG);
  localparam int unsigned STAGES     = (STAGES_RAW == 0) ? 1 : STAGES_RAW;

  if (!cla_width_ok(WIDTH, GRP_PER_STG)) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a non-zero multiple of 4*GRP_PER_STG");
  end

  // The stage record is declared here rather than in fma_pkg because its
  // field widths follow WIDTH. Operands travel whole; each stage overwrites
  // its own slice of s_done, so the last stage holds an aligned result.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] s_done;
    logic             carry;
  } stage_t;

  stage_t              stg_q [STAGES];
  stage_t              stg_d [STAGES];
  logic [STAGES-1:0]   adv;
  logic [WIDTH-1:0]    b_eff;
  logic                cin_eff;
  stage_t              last;

  assign b_eff   = bus.sub ? ~bus.in_b : bus.in_b;
  assign cin_eff = bus.c_in ^ bus.sub;

  // Advance chain walks down from the output so no stage reads a later bit
  // of the same vector that is still being resolved.
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = !stg_q[STAGES-1].valid | bus.out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      adv[STAGES-1-i] = !stg_q[STAGES-1-i].valid | adv[STAGES-i];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO = k * SW;

    stage_t          src;
    stage_t          nxt;
    logic [SW-1:0]   sum;

    if (k == 0) begin : g_front
      always_comb begin
        src.valid  = bus.in_valid;
        src.a_rem  = bus.in_a;
        src.b_rem  = b_eff;
        src.s_done = '0;
        src.carry  = cin_eff;
      end
    end else begin : g_chain
      assign src = stg_q[k-1];
    end

    for (genvar g = 0; g < GRP_PER_STG; g++) begin : g_grp
      logic ci;
      logic co;

      if (g == 0) begin : g_first
        assign ci = src.carry;
      end else begin : g_next
        assign ci = g_grp[g-1].co;
      end

      cla_group4 u_cla (
        .a     (src.a_rem[LO + g*CLA_GRP_W +: CLA_GRP_W]),
        .b     (src.b_rem[LO + g*CLA_GRP_W +: CLA_GRP_W]),
        .c_in  (ci),
        .s     (sum[g*CLA_GRP_W +: CLA_GRP_W]),
        .c_out (co)
      );
    end

    always_comb begin
      nxt                  = src;
      nxt.s_done[LO +: SW] = sum;
      nxt.carry            = g_grp[GRP_PER_STG-1].co;
    end

    assign stg_d[k] = nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) stg_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (adv[i]) stg_q[i] <= stg_d[i];
      end
    end
  end

  assign last          = stg_q[STAGES-1];
  assign bus.in_ready  = adv[0];
  assign bus.out_valid = last.valid;
  assign bus.s         = last.s_done;
  assign bus.c_out     = last.carry;
  assign bus.ovf       = (last.a_rem[WIDTH-1] == last.b_rem[WIDTH-1]) &
                         (last.s_done[WIDTH-1] != last.a_rem[WIDTH-1]);
  // Qualified by valid so an empty (reset) pipe does not report a zero result.
  assign bus.zero      = last.valid & ~(|last.s_done);

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: 32-bit/4-stage instance plus an 8-bit
// single-stage instance, checked against hand values and an arithmetic model.
module tb_cla_adder_pipe;

  localparam int unsigned W      = 32;
  localparam int          STAGES = 4;

  logic clk;
  logic rst_n;

  cla_adder_pipe_if #(.WIDTH(W)) bus ();
  cla_adder_pipe_if #(.WIDTH(8)) bus8 ();

  cla_adder_pipe #(.WIDTH(W), .GRP_PER_STG(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cla_adder_pipe #(.WIDTH(8), .GRP_PER_STG(2)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } vec32_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sb;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec8_t;

  typedef struct {
    logic [31:0] s;
    logic        c_out;
    logic        ovf;
    logic        zero;
    bit          lat;
    int          acc_cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_count = 0;
  exp_t        sbq[$];
  int          out_cyc[$];
  bit          held_ok = 0;
  bit          saw_full = 0;
  logic [34:0] held;

  vec32_t vt [12];
  vec8_t  v8 [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb, input bit lat);
    exp_t        m;
    logic [31:0] be;
    logic [32:0] r;
    be        = sb ? ~b : b;
    r         = {1'b0, a} + {1'b0, be} + {32'd0, ci ^ sb};
    m.s       = r[31:0];
    m.c_out   = r[32];
    m.ovf     = (a[31] == be[31]) && (r[31] != a[31]);
    m.zero    = (r[31:0] == 32'd0);
    m.lat     = lat;
    m.acc_cyc = 0;
    return m;
  endfunction

  // One clock of the 32-bit port; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb, input logic ordy,
                       input exp_t e, output bit acc);
    exp_t x;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.c_in      = ci;
    bus.sub       = sb;
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      out_count++;
      out_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        chk("spurious_out", {29'd0, bus.c_out, bus.ovf, bus.zero, bus.s}, 64'hDEAD);
      end else begin
        x = sbq.pop_front();
        chk("result", {29'd0, bus.c_out, bus.ovf, bus.zero, bus.s},
                      {29'd0, x.c_out, x.ovf, x.zero, x.s});
        if (x.lat) chk("latency", 64'(cyc - x.acc_cyc), 64'(STAGES));
      end
    end
    if (bus.out_valid && !bus.out_ready) begin
      if (held_ok) chk("stall_hold", {29'd0, bus.c_out, bus.ovf, bus.zero, bus.s}, {29'd0, held});
      held    = {bus.c_out, bus.ovf, bus.zero, bus.s};
      held_ok = 1'b1;
    end else begin
      held_ok = 1'b0;
    end
    if (v && bus.in_ready) begin
      e.acc_cyc = cyc;
      sbq.push_back(e);
      acc = 1'b1;
    end
    if (v && !bus.in_ready) saw_full = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    exp_t e;
    bit   acc;
    e = model(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ordy, e, acc);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sbq.size() > 0; i++) idle(1'b1);
    chk(name, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    exp_t        e;
    bit          acc;
    int          idx;
    int          sc;
    logic [31:0] ra [9];
    logic [31:0] rb [9];
    logic        rc [9];
    logic        rs [9];

    vt[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vt[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vt[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

    v8[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    v8[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    v8[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    v8[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    v8[4] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0, 1'b0};
    v8[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

    // Reset held with a beat offered: nothing may come out.
    rst_n          = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_a       = 32'h1;
    bus.in_b       = 32'h2;
    bus.c_in       = 1'b0;
    bus.sub        = 1'b0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.in_a      = 8'h1;
    bus8.in_b      = 8'h1;
    bus8.c_in      = 1'b0;
    bus8.sub       = 1'b0;
    bus8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_s", 64'(bus.s), 64'd0);
    chk("rst_flags", {61'd0, bus.c_out, bus.ovf, bus.zero}, 64'd0);
    chk("rst_out_valid8", 64'(bus8.out_valid), 64'd0);
    bus.in_valid  = 1'b0;
    bus8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

    // Back-to-back hand vectors, each with its latency checked.
    for (int i = 0; i < 12; i++) begin
      e.s = vt[i].s; e.c_out = vt[i].co; e.ovf = vt[i].ov; e.zero = vt[i].z;
      e.lat = 1'b1; e.acc_cyc = 0;
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++)
        cycle(1'b1, vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, 1'b1, e, acc);
      chk("table_accept", 64'(acc), 64'd1);
    end
    drain("table_drain");

    // Backpressure: 8 random beats, out_ready low for stream cycles 3..7.
    for (int i = 0; i < 9; i++) begin
      ra[i] = $urandom(); rb[i] = $urandom();
      rc[i] = 1'($urandom_range(1)); rs[i] = 1'($urandom_range(1));
    end
    out_count = 0;
    saw_full  = 1'b0;
    idx       = 0;
    for (int c = 0; c < 60 && (idx < 8 || sbq.size() > 0); c++) begin
      e = model(ra[idx], rb[idx], rc[idx], rs[idx], 1'b0);
      cycle(idx < 8, ra[idx], rb[idx], rc[idx], rs[idx], !(c >= 3 && c <= 7), e, acc);
      if (acc) idx++;
    end
    chk("bp_delivered", 64'(out_count), 64'd8);
    chk("bp_in_ready_drop", 64'(saw_full), 64'd1);
    chk("bp_sb_empty", 64'(sbq.size()), 64'd0);

    // Bubble collapse: beats at t and t+2, stall on cycles 4..6.
    out_cyc.delete();
    sc = cyc;
    for (int c = 0; c < 30 && (c < 3 || sbq.size() > 0); c++) begin
      e = model(ra[c], rb[c], 1'b0, 1'b0, 1'b0);
      cycle(c == 0 || c == 2, ra[c], rb[c], 1'b0, 1'b0, !(c >= 4 && c <= 6), e, acc);
    end
    chk("bubble_count", 64'(out_cyc.size()), 64'd2);
    if (out_cyc.size() == 2) begin
      chk("bubble_first_cyc", 64'(out_cyc[0] - sc), 64'd7);
      chk("bubble_back2back", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
    end

    // Reset with three beats in flight.
    for (int c = 0; c < 3; c++) begin
      e = model(rb[c], ra[c], 1'b1, 1'b0, 1'b0);
      cycle(1'b1, rb[c], ra[c], 1'b1, 1'b0, 1'b1, e, acc);
    end
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    sbq.delete();
    held_ok = 1'b0;
    #1;
    chk("midrst_flush", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 6; c++) begin
      chk("midrst_no_ghost", 64'(bus.out_valid), 64'd0);
      idle(1'b1);
    end
    e = model(32'hCAFE_0001, 32'h0000_0FFF, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'hCAFE_0001, 32'h0000_0FFF, 1'b0, 1'b1, 1'b1, e, acc);
    chk("midrst_accept", 64'(acc), 64'd1);
    drain("midrst_drain");

    // Single-stage 8-bit instance: result one cycle after acceptance.
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        bus8.in_valid = 1'b1;
        bus8.in_a     = v8[i].a;
        bus8.in_b     = v8[i].b;
        bus8.c_in     = v8[i].ci;
        bus8.sub      = v8[i].sb;
      end else begin
        bus8.in_valid = 1'b0;
      end
      #1;
      if (i < 6) chk("w8_in_ready", 64'(bus8.in_ready), 64'd1);
      if (i > 0) begin
        chk("w8_out_valid", 64'(bus8.out_valid), 64'd1);
        chk("w8_result", {53'd0, bus8.c_out, bus8.ovf, bus8.zero, bus8.s},
                         {53'd0, v8[i-1].co, v8[i-1].ov, v8[i-1].z, v8[i-1].s});
      end
      @(posedge clk);
      #1;
    end
    #1;
    chk("w8_empty", 64'(bus8.out_valid), 64'd0);

    chk("final_sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
